neo_crom_fetch: RTL and testbench

- Sits directly downstream of the PBUS address latch.
- Turns each sprite-address capture (C_LATCH, strobed by PCK1B) into one 64-bit read request to the SDRAM controller, then holds the returned sprite graphics word for the pixel serializer.
- Runs entirely in the system clock domain. PCK1B arrives as a level produced in this same domain, so no synchronizer is needed.

---
 rtl/neo_crom_fetch_if.sv | 26 ++
 rtl/neo_crom_fetch.sv | 204 ++++++++++++++++++++
 tb/tb_neo_crom_fetch.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/neo_crom_fetch_if.sv
// SDRAM read-port bundle between the C-ROM fetch unit (master) and the SDRAM controller (slave).
interface neo_crom_fetch_if #(
  parameter int ADDR_W = 27
);
  logic              sdr_req;
  logic [ADDR_W-1:0] sdr_addr;
  logic              sdr_ack;
  logic [63:0]       sdr_data;
  logic              sdr_ready;

  modport master (
    output sdr_req,
    output sdr_addr,
    input  sdr_ack,
    input  sdr_data,
    input  sdr_ready
  );

  modport slave (
    input  sdr_req,
    input  sdr_addr,
    output sdr_ack,
    output sdr_data,
    output sdr_ready
  );
endinterface

// File: rtl/neo_crom_fetch.sv
// C-ROM sprite fetch: turns each PCK1B rising edge into one 64-bit SDRAM read and holds the result.
// Optional statistics outputs (stat_reqs, stat_maxlat) are built when NEO_CROM_STATS_EN is defined.
module neo_crom_fetch #(
  parameter int                ADDR_W    = 27,
  parameter logic [ADDR_W-1:0] CROM_BASE = ADDR_W'(27'h0200000),
  parameter int                TIMEOUT   = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    pck1b,
  input  logic [19:0]             c_latch,
  input  logic                    ca4,
  neo_crom_fetch_if.master        sdr,
  output logic [63:0]             cr_data,
  output logic                    cr_valid,
  output logic                    overrun,
  output logic                    timeout_err
`ifdef NEO_CROM_STATS_EN
  ,
  output logic [15:0]             stat_reqs,
  output logic [7:0]              stat_maxlat
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t            state_reg, state_next;
  logic              pck_d_reg;
  logic              req_reg, req_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic              pend_reg, pend_next;
  logic [ADDR_W-1:0] paddr_reg, paddr_next;
  logic [7:0]        cnt_reg, cnt_next;
  logic [63:0]       data_reg, data_next;
  logic              valid_reg, valid_next;
  logic              ovr_reg, ovr_next;
  logic              tmo_reg, tmo_next;

  logic              trig;
  logic [ADDR_W-1:0] addr_cap;
  logic              busy_trig;
  logic              eff_pend;
  logic [ADDR_W-1:0] eff_paddr;
  logic              done;

  assign trig     = pck1b & ~pck_d_reg;
  assign addr_cap = CROM_BASE + ADDR_W'({c_latch, ca4, 3'b000});

  // A trigger arriving while busy is folded into the pending slot before any
  // exit decision, so a trigger coincident with completion is issued at once.
  assign busy_trig = trig && (state_reg != S_IDLE);
  assign eff_pend  = pend_reg | busy_trig;
  assign eff_paddr = busy_trig ? addr_cap : paddr_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      pck_d_reg <= 1'b1;
      req_reg   <= 1'b0;
      addr_reg  <= '0;
      pend_reg  <= 1'b0;
      paddr_reg <= '0;
      cnt_reg   <= '0;
      data_reg  <= '0;
      valid_reg <= 1'b0;
      ovr_reg   <= 1'b0;
      tmo_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      pck_d_reg <= pck1b;
      req_reg   <= req_next;
      addr_reg  <= addr_next;
      pend_reg  <= pend_next;
      paddr_reg <= paddr_next;
      cnt_reg   <= cnt_next;
      data_reg  <= data_next;
      valid_reg <= valid_next;
      ovr_reg   <= ovr_next;
      tmo_reg   <= tmo_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    req_next   = req_reg;
    addr_next  = addr_reg;
    pend_next  = pend_reg;
    paddr_next = paddr_reg;
    cnt_next   = cnt_reg;
    data_next  = data_reg;
    valid_next = 1'b0;
    ovr_next   = ovr_reg;
    tmo_next   = tmo_reg;
    done       = 1'b0;

    if (busy_trig && pend_reg) begin
      ovr_next = 1'b1;
    end

    case (state_reg)
      S_IDLE: begin
        if (trig) begin
          addr_next  = addr_cap;
          req_next   = 1'b1;
          state_next = S_REQ;
        end
      end
      S_REQ: begin
        if (sdr.sdr_ack) begin
          req_next   = 1'b0;
          cnt_next   = '0;
          state_next = S_WAIT;
          // Data in the acknowledge cycle completes the transfer immediately.
          if (sdr.sdr_ready) begin
            data_next  = sdr.sdr_data;
            valid_next = 1'b1;
            done       = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (sdr.sdr_ready) begin
          data_next  = sdr.sdr_data;
          valid_next = 1'b1;
          done       = 1'b1;
        end else if (cnt_reg == TMO_LAST) begin
          tmo_next = 1'b1;
          done     = 1'b1;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      default: begin
        state_next = S_IDLE;
        req_next   = 1'b0;
      end
    endcase

    if (done) begin
      pend_next = 1'b0;
      if (eff_pend) begin
        req_next   = 1'b1;
        addr_next  = eff_paddr;
        state_next = S_REQ;
      end else begin
        state_next = S_IDLE;
      end
    end else if (state_reg != S_IDLE) begin
      pend_next  = eff_pend;
      paddr_next = eff_paddr;
    end
  end

  assign sdr.sdr_req  = req_reg;
  assign sdr.sdr_addr = addr_reg;
  assign cr_data      = data_reg;
  assign cr_valid     = valid_reg;
  assign overrun      = ovr_reg;
  assign timeout_err  = tmo_reg;

`ifdef NEO_CROM_STATS_EN
  logic [15:0] reqs_reg;
  logic [7:0]  lat_reg;
  logic [7:0]  maxlat_reg;
  logic        issue;
  logic        take_ack;
  logic        take_ready;

  assign issue      = ((state_reg == S_IDLE) && trig) || (done && eff_pend);
  assign take_ack   = (state_reg == S_REQ) && sdr.sdr_ack;
  assign take_ready = (take_ack && sdr.sdr_ready) || ((state_reg == S_WAIT) && sdr.sdr_ready);

  // lat_reg equals the number of edges since the request was raised.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reqs_reg   <= '0;
      lat_reg    <= '0;
      maxlat_reg <= '0;
    end else begin
      if (take_ack && (reqs_reg != 16'hFFFF)) begin
        reqs_reg <= reqs_reg + 16'd1;
      end
      if (issue) begin
        lat_reg <= 8'd1;
      end else if (lat_reg != 8'hFF) begin
        lat_reg <= lat_reg + 8'd1;
      end
      if (take_ready && (lat_reg > maxlat_reg)) begin
        maxlat_reg <= lat_reg;
      end
    end
  end

  assign stat_reqs   = reqs_reg;
  assign stat_maxlat = maxlat_reg;
`endif

endmodule

// File: tb/tb_neo_crom_fetch.sv
// Directed + randomized bench for neo_crom_fetch against a transaction-level reference model.
module tb_neo_crom_fetch;
  localparam int ADDR_W  = 27;
  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pck1b;
  logic [19:0] c_latch;
  logic        ca4;
  logic [63:0] cr_data;
  logic        cr_valid;
  logic        overrun;
  logic        timeout_err;
`ifdef NEO_CROM_STATS_EN
  logic [15:0] stat_reqs;
  logic [7:0]  stat_maxlat;
`endif

  always #5 clk = ~clk;

  neo_crom_fetch_if #(.ADDR_W(ADDR_W)) sdr ();

  neo_crom_fetch #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pck1b       (pck1b),
    .c_latch     (c_latch),
    .ca4         (ca4),
    .sdr         (sdr),
    .cr_data     (cr_data),
    .cr_valid    (cr_valid),
    .overrun     (overrun),
    .timeout_err (timeout_err)
`ifdef NEO_CROM_STATS_EN
    ,
    .stat_reqs   (stat_reqs),
    .stat_maxlat (stat_maxlat)
`endif
  );

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Free-running monitors: edge count, CR_VALID pulses, request rise times.
  int   pcount = 0;
  int   vcount = 0;
  int   req_rise_cyc = 0;
  logic prev_req = 1'b0;

  always @(posedge clk) pcount++;

  always @(negedge clk) begin
    if (cr_valid === 1'b1) vcount++;
    if (sdr.sdr_req === 1'b1 && !prev_req) req_rise_cyc = pcount;
    prev_req = (sdr.sdr_req === 1'b1);
  end

  // Reference model: busy flag, one pending slot, queue of requests it expects to see.
  bit          m_busy;
  bit          m_pend;
  logic [26:0] m_paddr;
  logic [26:0] exp_q[$];
  logic [63:0] m_data;
  bit          m_ovr;
  bit          m_tmo;
  int          m_valid;
  int          m_reqs;
  int          m_maxlat;

  function automatic logic [26:0] crom_addr(logic [19:0] c, logic a);
    logic [31:0] s;
    s = 32'h0020_0000 + 32'(c) * 16 + (a ? 32'd8 : 32'd0);
    return s[26:0];
  endfunction

  task automatic m_edge(logic [26:0] addr);
    if (!m_busy) begin
      m_busy = 1'b1;
      exp_q.push_back(addr);
    end else if (m_pend) begin
      m_ovr   = 1'b1;
      m_paddr = addr;
    end else begin
      m_pend  = 1'b1;
      m_paddr = addr;
    end
  endtask

  task automatic m_done();
    if (m_pend) begin
      m_pend = 1'b0;
      exp_q.push_back(m_paddr);
    end else begin
      m_busy = 1'b0;
    end
  endtask

  task automatic m_reset();
    m_busy = 1'b0; m_pend = 1'b0; m_paddr = '0;
    exp_q.delete();
    m_data = '0; m_ovr = 1'b0; m_tmo = 1'b0;
    m_reqs = 0; m_maxlat = 0;
  endtask

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_edge(logic [19:0] c, logic a);
    tick();
    pck1b = 1'b1; c_latch = c; ca4 = a;
    m_edge(crom_addr(c, a));
    tick();
    pck1b = 1'b0;
  endtask

  task automatic finish_ok(logic [63:0] d, int lat_start);
    int lat;
    m_done();
    m_data = d;
    m_valid++;
    lat = pcount - lat_start;
    if (lat > 255) lat = 255;
    if (lat > m_maxlat) m_maxlat = lat;
    chk("valid_pulse", 64'(cr_valid), 64'd1);
    chk("cr_data", cr_data, d);
    tick();
    chk("valid_single", 64'(cr_valid), 64'd0);
  endtask

  // Play the SDRAM controller for one request; optionally inject edges during WAIT.
  task automatic serve(int ack_dly, int n_edges, int rdy_k, bit do_ready, bit coinc, bit ack_rdy);
    logic [63:0] d;
    logic [26:0] ea;
    logic [19:0] c;
    logic        a;
    int          w;
    int          lat_start;
    d = {$urandom(), $urandom()};
    w = 0;
    while (sdr.sdr_req !== 1'b1 && w < 20) begin
      tick();
      w++;
    end
    chk("req_raised", 64'(sdr.sdr_req), 64'd1);
    lat_start = req_rise_cyc;
    ea = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    chk("req_addr", 64'(sdr.sdr_addr), 64'(ea));
    repeat (ack_dly) tick();
    chk("req_hold", 64'({sdr.sdr_req, sdr.sdr_addr}), 64'({1'b1, ea}));
    sdr.sdr_ack = 1'b1;
    if (ack_rdy) begin
      sdr.sdr_ready = 1'b1;
      sdr.sdr_data  = d;
    end
    tick();
    sdr.sdr_ack = 1'b0;
    m_reqs++;
    if (ack_rdy) begin
      sdr.sdr_ready = 1'b0;
      finish_ok(d, lat_start);
    end else begin
      chk("req_drop", 64'(sdr.sdr_req), 64'd0);
      for (int k = 1; k <= TIMEOUT + 1; k++) begin
        tick();
        if (k <= 2 * n_edges) begin
          if (k % 2 == 1) begin
            c = 20'($urandom()); a = 1'($urandom());
            pck1b = 1'b1; c_latch = c; ca4 = a;
            m_edge(crom_addr(c, a));
          end else begin
            pck1b = 1'b0;
          end
        end
        if (do_ready && k == rdy_k) begin
          if (coinc) begin
            c = 20'($urandom()); a = 1'($urandom());
            pck1b = 1'b1; c_latch = c; ca4 = a;
            m_edge(crom_addr(c, a));
          end
          sdr.sdr_ready = 1'b1;
          sdr.sdr_data  = d;
        end
        if (do_ready && k == rdy_k + 1) begin
          sdr.sdr_ready = 1'b0;
          pck1b = 1'b0;
          finish_ok(d, lat_start);
          break;
        end
        if (!do_ready && k == TIMEOUT - 1) chk("tmo_not_yet", 64'(timeout_err), 64'(m_tmo));
        if (!do_ready && k == TIMEOUT) begin
          m_tmo = 1'b1;
          chk("tmo_set", 64'(timeout_err), 64'd1);
          m_done();
          break;
        end
      end
    end
    chk("overrun", 64'(overrun), 64'(m_ovr));
    chk("timeout_err", 64'(timeout_err), 64'(m_tmo));
    chk("valid_count", 64'(vcount), 64'(m_valid));
    chk("cr_data_hold", cr_data, m_data);
    if (!m_busy) chk("idle_no_req", 64'(sdr.sdr_req), 64'd0);
  endtask

  initial begin
    int ne;
    int guard;
    logic [26:0] ea;
    m_reset();
    m_valid = 0;
    rst_n = 1'b0; pck1b = 1'b1; c_latch = '0; ca4 = 1'b0;
    sdr.sdr_ack = 1'b0; sdr.sdr_ready = 1'b0; sdr.sdr_data = '0;

    // Reset state, with PCK1B already high across release.
    repeat (3) tick();
    chk("rst_req", 64'(sdr.sdr_req), 64'd0);
    chk("rst_addr", 64'(sdr.sdr_addr), 64'd0);
    chk("rst_data", cr_data, 64'd0);
    chk("rst_valid", 64'(cr_valid), 64'd0);
    chk("rst_ovr", 64'(overrun), 64'd0);
    chk("rst_tmo", 64'(timeout_err), 64'd0);
    rst_n = 1'b1;
    repeat (4) tick();
    chk("release_high_no_req", 64'(sdr.sdr_req), 64'd0);
    pck1b = 1'b0;
    tick();

    // Basic fetch.
    pulse_edge(20'h12345, 1'b1);
    serve(3, 0, 5, 1'b1, 1'b0, 1'b0);

    // Back-to-back: one edge during WAIT becomes the next request.
    pulse_edge(20'($urandom()), 1'($urandom()));
    serve(2, 1, 8, 1'b1, 1'b0, 1'b0);
    serve(1, 0, 4, 1'b1, 1'b0, 1'b0);

    // Overrun: two edges during WAIT, newest wins.
    pulse_edge(20'($urandom()), 1'($urandom()));
    serve(2, 2, 9, 1'b1, 1'b0, 1'b0);
    serve(0, 0, 3, 1'b1, 1'b0, 1'b0);

    // Timeout, then a normal fetch.
    pulse_edge(20'($urandom()), 1'($urandom()));
    serve(1, 0, 0, 1'b0, 1'b0, 1'b0);
    pulse_edge(20'($urandom()), 1'($urandom()));
    serve(2, 0, 6, 1'b1, 1'b0, 1'b0);

    // READY on the last WAIT cycle still wins over the timeout.
    pulse_edge(20'($urandom()), 1'($urandom()));
    serve(1, 0, TIMEOUT - 1, 1'b1, 1'b0, 1'b0);

    // ACK and READY in the same cycle.
    pulse_edge(20'hFFFFF, 1'b1);
    serve(2, 0, 0, 1'b1, 1'b0, 1'b1);

    // Edge coincident with READY is issued next.
    pulse_edge(20'($urandom()), 1'($urandom()));
    serve(1, 0, 5, 1'b1, 1'b1, 1'b0);
    serve(1, 0, 2, 1'b1, 1'b0, 1'b0);

    // ACK/READY while idle are ignored.
    sdr.sdr_ack = 1'b1; sdr.sdr_ready = 1'b1; sdr.sdr_data = {$urandom(), $urandom()};
    tick();
    sdr.sdr_ack = 1'b0; sdr.sdr_ready = 1'b0;
    tick();
    chk("idle_ack_ignored", 64'(sdr.sdr_req), 64'd0);
    chk("idle_ready_ignored", 64'(vcount), 64'(m_valid));
    chk("idle_data_kept", cr_data, m_data);

    // Reset in the middle of WAIT; late READY must not produce data.
    pulse_edge(20'($urandom()), 1'($urandom()));
    ea = exp_q.pop_front();
    chk("rst_case_addr", 64'(sdr.sdr_addr), 64'(ea));
    tick();
    sdr.sdr_ack = 1'b1;
    tick();
    sdr.sdr_ack = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0; pck1b = 1'b1;
    tick();
    sdr.sdr_ready = 1'b1; sdr.sdr_data = {$urandom(), $urandom()};
    tick();
    sdr.sdr_ready = 1'b0;
    m_reset();
    chk("mid_rst_req", 64'(sdr.sdr_req), 64'd0);
    chk("mid_rst_addr", 64'(sdr.sdr_addr), 64'd0);
    chk("mid_rst_data", cr_data, 64'd0);
    chk("mid_rst_valid", 64'(vcount), 64'(m_valid));
    chk("mid_rst_flags", 64'({overrun, timeout_err}), 64'd0);
    rst_n = 1'b1;
    repeat (5) tick();
    chk("mid_rst_release_no_req", 64'(sdr.sdr_req), 64'd0);
    pck1b = 1'b0;
    tick();

    // Randomized transactions.
    for (int it = 0; it < 15; it++) begin
      pulse_edge(20'($urandom()), 1'($urandom()));
      guard = 0;
      while (m_busy && guard < 10) begin
        ne = (guard == 0) ? int'($urandom_range(0, 2)) : 0;
        serve(int'($urandom_range(0, 4)), ne, 2 * ne + int'($urandom_range(1, 12)),
              ($urandom_range(0, 7) != 0), ($urandom_range(0, 3) == 0), 1'b0);
        guard++;
      end
    end

`ifdef NEO_CROM_STATS_EN
    chk("stat_reqs", 64'(stat_reqs), 64'(m_reqs));
    chk("stat_maxlat", 64'(stat_maxlat), 64'(m_maxlat));
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
